// File: rtl/tod_pkg.sv
// Shared constants and helpers for the time-of-day counter.
// Holds the field widths, the per-field maximum values and the
// 24-hour to display-hour decode used by time_of_day_counter.
package tod_pkg;

    localparam int unsigned HOUR_W   = 5;
    localparam int unsigned MIN_W    = 6;
    localparam int unsigned SEC_W    = 6;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    // Hour field as presented on the display outputs
    typedef struct packed {
        logic              pm;
        logic [HOUR_W-1:0] hours;
    } disp_hour_t;

    // Map an internal 0..23 hour to the display encoding
    function automatic disp_hour_t to_display(input logic [HOUR_W-1:0] h,
                                              input logic              mode_24h);
        disp_hour_t d;
        d.pm    = 1'b0;
        d.hours = h;
        if (!mode_24h) begin
            d.pm = (h >= HOUR_W'(12));
            if (h == HOUR_W'(0) || h == HOUR_W'(12)) begin
                d.hours = HOUR_W'(12);
            end else if (h > HOUR_W'(12)) begin
                d.hours = h - HOUR_W'(12);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter stage with synchronous load.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   inc             - advance by one (wraps MAX -> 0)
//   load, load_val  - load value, takes priority over inc
//   value           - current count (registered)
//   wrap            - high when inc is applied while value == MAX
module mod_counter #(
    parameter int unsigned MAX   = 59,
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    // Carry into the next stage; consumed in the same cycle
    assign wrap = inc && (value == WIDTH'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= wrap ? '0 : value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// Time-of-day clock: prescaler-derived 1 Hz strobe advancing h:m:s,
// with a load handshake and rollover tick pulses.
// Optional alarm enabled by defining TOD_ALARM_EN.
// Ports:
//   clk, reset                       - clock, asynchronous active-high reset
//   run                              - 1 = time advances, 0 = frozen
//   set_valid, set_hours/minutes/seconds - load request, 24-hour encoding
//   set_ready                        - load accepted this cycle when high
//   set_err                          - one-cycle pulse after an out-of-range load
//   hours, minutes, seconds, pm      - current time in display encoding
//   sec_tick, min_tick, hour_tick, day_tick - rollover pulses
//   alarm_wr, alarm_hours, alarm_minutes, alarm - (TOD_ALARM_EN only)
module time_of_day_counter
    import tod_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned MODE_24H = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              set_valid,
    input  logic [HOUR_W-1:0] set_hours,
    input  logic [MIN_W-1:0]  set_minutes,
    input  logic [SEC_W-1:0]  set_seconds,
`ifdef TOD_ALARM_EN
    input  logic              alarm_wr,
    input  logic [HOUR_W-1:0] alarm_hours,
    input  logic [MIN_W-1:0]  alarm_minutes,
    output logic              alarm,
`endif
    output logic              set_ready,
    output logic              set_err,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic              pm,
    output logic              sec_tick,
    output logic              min_tick,
    output logic              hour_tick,
    output logic              day_tick
);

    localparam int unsigned PRE_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic        IS_24 = (MODE_24H != 0);

    logic [PRE_W-1:0]  presc;
    logic              strobe;
    logic              accept;
    logic              set_ok;
    logic              tick;
    logic              s_wrap, m_wrap, h_wrap;
    logic [HOUR_W-1:0] h;
    logic [MIN_W-1:0]  m;
    logic [SEC_W-1:0]  s;
    logic [HOUR_W-1:0] h_nxt;
    disp_hour_t        disp;

    assign strobe = run && (presc == PRE_W'(CLK_HZ - 1));
    assign accept = set_valid && set_ready;
    assign set_ok = accept
                 && (set_hours   <= HOUR_W'(HOUR_MAX))
                 && (set_minutes <= MIN_W'(MIN_MAX))
                 && (set_seconds <= SEC_W'(SEC_MAX));
    // Any accepted load, valid or not, suppresses a coinciding strobe
    assign tick   = strobe && !accept;

    // Prescaler: restarts on a valid load, otherwise counts while running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (set_ok) begin
            presc <= '0;
        end else if (run) begin
            presc <= strobe ? '0 : presc + PRE_W'(1);
        end
    end

    mod_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
        .clk(clk), .reset(reset), .inc(tick), .load(set_ok),
        .load_val(set_seconds), .value(s), .wrap(s_wrap)
    );

    mod_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
        .clk(clk), .reset(reset), .inc(s_wrap), .load(set_ok),
        .load_val(set_minutes), .value(m), .wrap(m_wrap)
    );

    mod_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
        .clk(clk), .reset(reset), .inc(m_wrap), .load(set_ok),
        .load_val(set_hours), .value(h), .wrap(h_wrap)
    );

    // Next hour value, so the decoded display hour can be registered
    always_comb begin
        h_nxt = h;
        if (set_ok) begin
            h_nxt = set_hours;
        end else if (m_wrap) begin
            h_nxt = h_wrap ? '0 : h + HOUR_W'(1);
        end
    end

    // Handshake, error pulse, tick pulses and display hour
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_ready <= 1'b1;
            set_err   <= 1'b0;
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
            disp      <= to_display('0, IS_24);
        end else begin
            set_ready <= !accept;
            set_err   <= accept && !set_ok;
            sec_tick  <= tick;
            min_tick  <= s_wrap;
            hour_tick <= m_wrap;
            day_tick  <= h_wrap;
            disp      <= to_display(h_nxt, IS_24);
        end
    end

    assign hours   = disp.hours;
    assign pm      = disp.pm;
    assign minutes = m;
    assign seconds = s;

`ifdef TOD_ALARM_EN
    logic [HOUR_W-1:0] alarm_h;
    logic [MIN_W-1:0]  alarm_m;
    logic [MIN_W-1:0]  m_nxt;

    assign m_nxt = s_wrap ? (m_wrap ? '0 : m + MIN_W'(1)) : m;

    // Alarm fires when the time advances onto hh:mm:00 of the stored alarm
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_h <= '0;
            alarm_m <= '0;
            alarm   <= 1'b0;
        end else if (alarm_wr) begin
            alarm_h <= alarm_hours;
            alarm_m <= alarm_minutes;
            alarm   <= 1'b0;
        end else if (s_wrap && (h_nxt == alarm_h) && (m_nxt == alarm_m)) begin
            alarm   <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Testbench for time_of_day_counter (CLK_HZ=4, 12-hour display).
module tb_time_of_day_counter;

    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       set_valid;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;
    logic       set_ready;
    logic       set_err;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       pm;
    logic       sec_tick, min_tick, hour_tick, day_tick;

    int total = 0;
    int bad   = 0;

    // Reference model: time as seconds since midnight
    int m_t, m_presc;
    bit m_ready, m_err, m_st, m_mt, m_ht, m_dt;

    typedef struct {
        int h, m, s, strobes;
        int eh, em, es, epm, emt, eht, edt, eerr;
    } vec_t;

    vec_t vecs[10];

    time_of_day_counter #(.CLK_HZ(CLK_HZ), .MODE_24H(0)) dut (
        .clk(clk), .reset(reset), .run(run), .set_valid(set_valid),
        .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
        .set_ready(set_ready), .set_err(set_err),
        .hours(hours), .minutes(minutes), .seconds(seconds), .pm(pm),
        .sec_tick(sec_tick), .min_tick(min_tick), .hour_tick(hour_tick), .day_tick(day_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_t = 0; m_presc = 0; m_ready = 1'b1; m_err = 1'b0;
        m_st = 1'b0; m_mt = 1'b0; m_ht = 1'b0; m_dt = 1'b0;
    endfunction

    function automatic void model_edge();
        bit acc, ok, strobe;
        if (reset) begin
            model_reset();
        end else begin
            acc = set_valid && m_ready;
            ok  = acc && (int'(set_hours) <= 23) && (int'(set_minutes) <= 59)
                      && (int'(set_seconds) <= 59);
            strobe = run && (m_presc == CLK_HZ - 1);
            m_st = 1'b0; m_mt = 1'b0; m_ht = 1'b0; m_dt = 1'b0;
            if (ok) begin
                m_t = int'(set_hours) * 3600 + int'(set_minutes) * 60 + int'(set_seconds);
                m_presc = 0;
            end else begin
                if (run) m_presc = (m_presc + 1) % CLK_HZ;
                if (strobe && !acc) begin
                    m_t  = (m_t + 1) % 86400;
                    m_st = 1'b1;
                    m_mt = (m_t % 60) == 0;
                    m_ht = (m_t % 3600) == 0;
                    m_dt = (m_t == 0);
                end
            end
            m_err   = acc && !ok;
            m_ready = !acc;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model();
        int hh;
        hh = m_t / 3600;
        chk("rnd_hours",   32'(hours),   32'((hh % 12 == 0) ? 12 : hh % 12));
        chk("rnd_minutes", 32'(minutes), 32'((m_t / 60) % 60));
        chk("rnd_seconds", 32'(seconds), 32'(m_t % 60));
        chk("rnd_pm",      32'(pm),      32'(hh >= 12));
        chk("rnd_sec_tick",  32'(sec_tick),  32'(m_st));
        chk("rnd_min_tick",  32'(min_tick),  32'(m_mt));
        chk("rnd_hour_tick", 32'(hour_tick), 32'(m_ht));
        chk("rnd_day_tick",  32'(day_tick),  32'(m_dt));
        chk("rnd_set_ready", 32'(set_ready), 32'(m_ready));
        chk("rnd_set_err",   32'(set_err),   32'(m_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hours"},   32'(hours), 32'd12);
        chk({tag, "_minutes"}, 32'(minutes), 32'd0);
        chk({tag, "_seconds"}, 32'(seconds), 32'd0);
        chk({tag, "_pm"},      32'(pm), 32'd0);
        chk({tag, "_ticks"},   32'({sec_tick, min_tick, hour_tick, day_tick}), 32'd0);
        chk({tag, "_set_err"}, 32'(set_err), 32'd0);
        chk({tag, "_set_ready"}, 32'(set_ready), 32'd1);
    endtask

    task automatic load(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hours = 5'(h); set_minutes = 6'(m); set_seconds = 6'(s);
        step();
        set_valid = 1'b0;
    endtask

    initial begin
        //        h   m   s  stb  eh  em  es pm mt ht dt err
        vecs[0] = '{ 0, 59, 59, 1,  1,  0,  0, 0, 1, 1, 0, 0};
        vecs[1] = '{23, 59, 59, 1, 12,  0,  0, 0, 1, 1, 1, 0};
        vecs[2] = '{13,  5,  0, 0,  1,  5,  0, 1, 0, 0, 0, 0};
        vecs[3] = '{12,  0,  0, 0, 12,  0,  0, 1, 0, 0, 0, 0};
        vecs[4] = '{24,  0,  0, 0, 12,  0,  0, 1, 0, 0, 0, 1};
        vecs[5] = '{11, 59, 59, 1, 12,  0,  0, 1, 1, 1, 0, 0};
        vecs[6] = '{10, 20, 30, 0, 10, 20, 30, 0, 0, 0, 0, 0};
        vecs[7] = '{10, 60,  0, 0, 10, 20, 30, 0, 0, 0, 0, 1};
        vecs[8] = '{ 0,  0,  0, 0, 12,  0,  0, 0, 0, 0, 0, 0};
        vecs[9] = '{ 5,  7, 58, 1,  5,  7, 59, 0, 0, 0, 0, 0};

        reset = 1'b1; run = 1'b0; set_valid = 1'b0;
        set_hours = '0; set_minutes = '0; set_seconds = '0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        step(); step();
        reset = 1'b0;

        // First second after reset with run held high
        run = 1'b1;
        for (int i = 0; i < CLK_HZ - 1; i++) step();
        chk("pre_strobe_seconds", 32'(seconds), 32'd0);
        chk("pre_strobe_sec_tick", 32'(sec_tick), 32'd0);
        step();
        chk("first_second", 32'(seconds), 32'd1);
        chk("first_sec_tick", 32'(sec_tick), 32'd1);
        run = 1'b0;

        // Table: load a value, optionally run one strobe, compare
        foreach (vecs[i]) begin
            load(vecs[i].h, vecs[i].m, vecs[i].s);
            chk($sformatf("v%0d_ready_low", i), 32'(set_ready), 32'd0);
            chk($sformatf("v%0d_set_err", i), 32'(set_err), 32'(vecs[i].eerr));
            if (vecs[i].strobes > 0) begin
                run = 1'b1;
                for (int k = 0; k < CLK_HZ * vecs[i].strobes; k++) step();
                run = 1'b0;
            end
            chk($sformatf("v%0d_hours", i),   32'(hours),   32'(vecs[i].eh));
            chk($sformatf("v%0d_minutes", i), 32'(minutes), 32'(vecs[i].em));
            chk($sformatf("v%0d_seconds", i), 32'(seconds), 32'(vecs[i].es));
            chk($sformatf("v%0d_pm", i),      32'(pm),      32'(vecs[i].epm));
            chk($sformatf("v%0d_sec_tick", i),  32'(sec_tick),  32'(vecs[i].strobes > 0));
            chk($sformatf("v%0d_min_tick", i),  32'(min_tick),  32'(vecs[i].emt));
            chk($sformatf("v%0d_hour_tick", i), 32'(hour_tick), 32'(vecs[i].eht));
            chk($sformatf("v%0d_day_tick", i),  32'(day_tick),  32'(vecs[i].edt));
            if (vecs[i].strobes == 0) begin
                step();
                chk($sformatf("v%0d_ready_back", i), 32'(set_ready), 32'd1);
                chk($sformatf("v%0d_err_clear", i), 32'(set_err), 32'd0);
            end
        end

        // Load landing on the same edge as a strobe
        load(0, 0, 0);
        run = 1'b1;
        for (int i = 0; i < CLK_HZ - 1; i++) step();
        load(7, 8, 9);
        chk("coincide_hours",   32'(hours),   32'd7);
        chk("coincide_minutes", 32'(minutes), 32'd8);
        chk("coincide_seconds", 32'(seconds), 32'd9);
        chk("coincide_ticks", 32'({sec_tick, min_tick, hour_tick, day_tick}), 32'd0);
        for (int i = 0; i < CLK_HZ; i++) step();
        chk("coincide_next_second", 32'(seconds), 32'd10);

        // Random traffic against the reference model
        for (int c = 0; c < 800; c++) begin
            run       = ($urandom_range(0, 9) != 0);
            set_valid = ($urandom_range(0, 14) == 0);
            set_hours   = ($urandom_range(0, 3) == 0) ? 5'd23 : 5'($urandom_range(0, 24));
            set_minutes = ($urandom_range(0, 1) == 0) ? 6'd59 : 6'($urandom_range(0, 60));
            set_seconds = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(57, 59))
                                                      : 6'($urandom_range(0, 60));
            step();
            check_model();
        end
        set_valid = 1'b0;

        // Asynchronous reset in the middle of a count
        load(10, 20, 30);
        run = 1'b1;
        for (int i = 0; i < 6; i++) step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        step();
        reset = 1'b0;
        run = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, clk cycles per second (integer >= 2).
REQ-002 SHALL have parameter MODE_24H, default 0; 0 = 12-hour display (1..12 plus pm), 1 = 24-hour display (0..23).
REQ-003 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port run, input, 1, 1 = time advances, 0 = time frozen (prescaler holds).
REQ-006 SHALL have port set_valid, input, 1, load request.
REQ-007 SHALL have ports set_hours [4:0], set_minutes [5:0], set_seconds [5:0], input, load value, always in 24-hour encoding 0..23.
REQ-008 SHALL have port set_ready, output, 1, block accepts a load this cycle.
REQ-009 SHALL have port set_err, output, 1, one-cycle pulse when a load value is out of range.
REQ-010 SHALL have ports hours [4:0], minutes [5:0], seconds [5:0], pm, output, current time in display encoding.
REQ-011 SHALL have ports sec_tick, min_tick, hour_tick, day_tick, output, 1, one-cycle pulses on each rollover.

Function
REQ-012 SHALL derive a 1 Hz strobe from a prescaler counting 0..CLK_HZ-1 while run=1; the strobe asserts on the cycle the prescaler wraps.
REQ-013 SHALL hold time internally as 24-hour h (0..23), m, s (0..59), all advanced synchronously in one cycle on the strobe; no derived clocks or ripple edges.
REQ-014 On the strobe: s increments; at s=59, s->0, m increments; at m=59, m->0, h increments; at h=23, h->0.
REQ-015 sec_tick SHALL pulse on every strobe; min_tick when s wraps; hour_tick when m and s wrap together; day_tick when 23:59:59 -> 00:00:00; all pulses on the same cycle the registers update.
REQ-016 MODE_24H=1: hours = h, pm = 0.
REQ-017 MODE_24H=0: hours = 12 when h is 0 or 12, else h mod 12; pm = 1 for h in 12..23.
REQ-018 set_ready SHALL be 1 except during the cycle after an accepted load (a one-cycle busy slot).
REQ-019 A load SHALL be accepted when set_valid and set_ready are both 1; from the next cycle, h/m/s equal the set values and the prescaler is 0.
REQ-020 A load with set_hours>23, set_minutes>59 or set_seconds>59 SHALL leave the time unchanged, pulse set_err the next cycle and still consume the handshake.
REQ-021 A load coinciding with a strobe SHALL win; no rollover pulses are emitted that cycle.
REQ-022 Outputs SHALL be registered or decoded from registers only; no combinational path from set_* to the time outputs.

Reset
REQ-023 On reset SHALL set h=0, m=0, s=0 and prescaler=0; outputs show 12:00:00 with pm=0 (MODE_24H=0) or 00:00:00 (MODE_24H=1).
REQ-024 During reset SHALL drive all tick pulses and set_err to 0 and set_ready to 1; reset mid-load discards the load.

Configuration
REQ-025 With TOD_ALARM_EN defined SHALL add inputs alarm_wr, alarm_hours [4:0], alarm_minutes [5:0] and output alarm, which latches at 1 when h:m equals the stored alarm and s=0 on a strobe, and clears on alarm_wr or reset; the stored alarm resets to 00:00.
REQ-026 Without TOD_ALARM_EN those ports and their logic SHALL not exist; all other behaviour is identical.

Structure
REQ-027 Package tod_pkg SHALL hold the constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23 and the field widths 5/6/6.
REQ-028 A sub-module mod_counter (parameter MAX; inputs inc, load, load_val; outputs value, wrap) SHALL be used for the s, m and h stages.

Verification
REQ-029 CLK_HZ=4, reset, run=1: seconds=1 after 4 clk cycles, sec_tick asserted on that cycle.
REQ-030 Load 00:59:59, one strobe: output 01:00:00, with min_tick and hour_tick on the same cycle and day_tick=0.
REQ-031 Load 23:59:59, one strobe: output 00:00:00 with day_tick=1; MODE_24H=0 shows 12:00:00, pm=0.
REQ-032 MODE_24H=0, load 13:05:00: hours=1, pm=1; load 12:00:00: hours=12, pm=1.
REQ-033 Load 24:00:00: set_err pulses, time is unchanged, set_ready is low for one cycle.
REQ-034 Load asserted on the same cycle as a strobe: the loaded value appears with no tick pulses; reset asserted mid-count returns all outputs to the reset values asynchronously.
